// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
// Optional parity support in uart_rx_16x is enabled with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int OVS_DEF   = 16;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Tick index within a bit period of majority sample k (0..2); the last one is the decision tick.
    function automatic int samp_tick(input int ovs, input int k);
        return ovs / 2 - 2 + k;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two byte FIFO between the receiver FSM and the command processor.
// No same-cycle bypass: a byte pushed into an empty FIFO becomes visible one cycle later.
module uart_rx_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] head_o,
    output logic         push_full_o
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_q, rd_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic [IW-1:0] widx, ridx;
    logic          empty, full, do_pop, do_push;

    assign empty   = (wr_q == rd_q);
    // Equivalent to "MSBs differ, remaining bits equal" for power-of-two depths.
    assign full    = ((wr_q - rd_q) == PW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);
    assign widx    = IW'(wr_q) & IW'(DEPTH - 1);
    assign ridx    = IW'(rd_q) & IW'(DEPTH - 1);

    assign vld_o       = ~empty;
    assign head_o      = mem_q[ridx];
    assign push_full_o = push_i & full & ~do_pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[widx] <= din_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receive front end with 3-sample majority voting and an output FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (par_odd input, par_err output).
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int OVS   = OVS_DEF,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    input  logic       rdy_rx,
    output logic       vld_rx,
    output logic [7:0] d_rx,
    output logic       frm_err,
`ifdef UART_RX_PARITY_EN
    input  logic       par_odd,
    output logic       par_err,
`endif
    output logic       ovf
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T0    = TW'(samp_tick(OVS, 0));
    localparam logic [TW-1:0] T1    = TW'(samp_tick(OVS, 1));
    localparam logic [TW-1:0] T2    = TW'(samp_tick(OVS, 2));
    localparam logic [TW-1:0] TLAST = TW'(OVS - 1);

    logic                 sync1_q, rxs_q;
    logic [1:0]           fill_q;
    logic                 armed_q;
    rx_state_t            state_q;
    logic [TW-1:0]        tc_q;
    logic [2:0]           bc_q;
    logic [1:0]           smp_q;
    logic [DATA_BITS-1:0] shr_q;
    logic                 frm_err_q, ovf_q;
    logic                 maj, decide, push, push_full, fifo_vld;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_err_q, par_bad;
`endif

    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    assign decide = (tc_q == T2);

`ifdef UART_RX_PARITY_EN
    assign par_bad = ((^shr_q) ^ par_bit_q) != par_odd;
    assign push    = (state_q == STOP) && decide && maj && !par_bad;
    assign par_err = par_err_q;
`else
    assign push    = (state_q == STOP) && decide && maj;
`endif

    assign frm_err = frm_err_q;
    assign ovf     = ovf_q;
    assign vld_rx  = fifo_vld;

    // Synchronizer; armed_q only sets once rxs_q reflects a genuinely idle line,
    // so a line held low through reset never starts a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if (fill_q == 2'd2 && rxs_q) begin
                armed_q <= 1'b1;
            end
            ovf_q <= push_full;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tc_q      <= '0;
            bc_q      <= '0;
            smp_q     <= 2'b11;
            shr_q     <= '0;
            frm_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            frm_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            tc_q <= tc_q + TW'(1);
            if (tc_q == T0) smp_q[0] <= rxs_q;
            if (tc_q == T1) smp_q[1] <= rxs_q;

            case (state_q)
                IDLE: begin
                    // The detection cycle itself is tick 0.
                    tc_q <= TW'(1);
                    if (armed_q && !rxs_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (decide && maj) begin
                        state_q <= IDLE;
                    end else if (tc_q == TLAST) begin
                        state_q <= DATA;
                        bc_q    <= '0;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shr_q <= {maj, shr_q[DATA_BITS-1:1]};
                    end
                    if (tc_q == TLAST) begin
                        bc_q <= bc_q + 3'd1;
                        if (bc_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) par_bit_q <= maj;
                    if (tc_q == TLAST) state_q <= STOP;
                end
`endif
                STOP: begin
                    if (decide) begin
                        if (!maj) begin
                            frm_err_q <= 1'b1;
                            state_q   <= BREAK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            par_err_q <= par_bad;
`endif
                            state_q <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (rxs_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .din_i       (shr_q),
        .pop_i       (rdy_rx),
        .vld_o       (fifo_vld),
        .head_o      (d_rx),
        .push_full_o (push_full)
    );

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x (default 8N1 build, OVS=16, DEPTH=2).
module tb_uart_rx_16x;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rxd;
    logic       rdy_rx;
    logic       vld_rx;
    logic [7:0] d_rx;
    logic       frm_err;
    logic       ovf;

    uart_rx_16x dut (
        .clk     (clk),
        .rstn    (rstn),
        .rxd     (rxd),
        .rdy_rx  (rdy_rx),
        .vld_rx  (vld_rx),
        .d_rx    (d_rx),
        .frm_err (frm_err),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         frm_seen = 0;
    int         ovf_seen = 0;
    int         vld_cycles = 0;
    int         rise_cyc = -1;
    int         fstart = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and counts flag pulses.
    initial begin
        logic       vld_prev;
        logic [7:0] e;
        vld_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (vld_rx) vld_cycles++;
                if (vld_rx && !vld_prev) rise_cyc = cyc;
                if (vld_rx && rdy_rx) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", d_rx);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", int'(d_rx), int'(e));
                    end
                end
                if (frm_err) frm_seen++;
                if (ovf) ovf_seen++;
                if (frm_err && ovf) begin
                    checks++;
                    errors++;
                    $display("FAIL frm_ovf_together: got both high, expected at most one");
                end
            end
            vld_prev = vld_rx;
        end
    end

    // One 10-bit frame, 16 clocks per bit. pulse_at raises rdy_rx for that one cycle;
    // rst_at pulses rstn in that cycle and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int pulse_at, input int rst_at);
        logic [9:0] bits;
        bits   = {stop_bit, b, 1'b0};
        fstart = cyc;
        for (int i = 0; i < 160; i++) begin
            rxd = bits[i / 16];
            if (pulse_at >= 0) begin
                if (i == pulse_at) rdy_rx = 1'b1;
                else if (i == pulse_at + 1) rdy_rx = 1'b0;
            end
            if (i == rst_at) begin
                rstn = 1'b0;
                #1;
                check("rst_mid_vld", int'(vld_rx), 0);
                check("rst_mid_d_rx", int'(d_rx), 0);
                check("rst_mid_frm_err", int'(frm_err), 0);
                check("rst_mid_ovf", int'(ovf), 0);
                rxd  = 1'b1;
                #1;
                rstn = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int v0;
        rstn   = 1'b0;
        rxd    = 1'b1;
        rdy_rx = 1'b1;
        idle(3);
        check("reset_vld", int'(vld_rx), 0);
        check("reset_d_rx", int'(d_rx), 0);
        check("reset_frm_err", int'(frm_err), 0);
        check("reset_ovf", int'(ovf), 0);
        rstn = 1'b1;
        idle(6);

        // 0x55: vld_rx for exactly one cycle, first at S+153 where S = start drive + 2.
        rise_cyc = -1;
        v0 = vld_cycles;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, -1);
        idle(4);
        check("t1_latency", rise_cyc, fstart + 155);
        check("t1_vld_cycles", vld_cycles - v0, 1);
        check("t1_frm_err", frm_seen, 0);
        check("t1_ovf", ovf_seen, 0);

        // Short low glitch is rejected; following frame still decodes.
        v0 = vld_cycles;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        check("t2_glitch_no_vld", vld_cycles - v0, 0);
        check("t2_glitch_no_frm", frm_seen, 0);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, -1, -1);
        wait_drain("t2_drain");

        // Framing error then break; next frame recovers.
        v0 = vld_cycles;
        send_frame(8'h3C, 1'b0, -1, -1);
        rxd = 1'b0;
        idle(40);
        rxd = 1'b1;
        idle(20);
        check("t3_frm_err_pulses", frm_seen, 1);
        check("t3_no_push", vld_cycles - v0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, -1);
        wait_drain("t3_drain");

        // Overflow: third byte dropped while consumer stalls.
        rdy_rx = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        send_frame(8'h33, 1'b1, -1, -1);
        idle(2);
        check("t4_ovf_pulses", ovf_seen, 1);
        check("t4_head_held", int'(d_rx), 8'h11);
        rdy_rx = 1'b1;
        wait_drain("t4_drain");
        idle(2);
        check("t4_empty_after", int'(vld_rx), 0);

        // Full FIFO with pop on the push edge: no overflow.
        rdy_rx = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        send_frame(8'h33, 1'b1, 154, -1);
        idle(2);
        check("t5_no_ovf", ovf_seen, 1);
        check("t5_head", int'(d_rx), 8'h22);
        rdy_rx = 1'b1;
        wait_drain("t5_drain");
        idle(2);
        check("t5_empty_after", int'(vld_rx), 0);

        // Reset during data bit 4 with a byte pending; FIFO contents discarded.
        rdy_rx = 1'b0;
        send_frame(8'h77, 1'b1, -1, -1);
        idle(2);
        check("t6_pending_head", int'(d_rx), 8'h77);
        send_frame(8'h5A, 1'b1, -1, 84);
        idle(20);
        rdy_rx = 1'b1;
        idle(2);
        check("t6_empty_after_rst", int'(vld_rx), 0);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, -1, -1);
        wait_drain("t6_drain");
        check("t6_frm_err", frm_seen, 1);
        check("t6_ovf", ovf_seen, 1);

        idle(5);
        check("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

endmodule
